// File: rtl/refresh_scheduler_if.sv
// refresh_scheduler_if: handshake between the refresh scheduler and the RAM
// controller.
//   RefAck    : controller -> scheduler, one-cycle pulse, refresh started
//   RefReq    : scheduler -> controller, refresh requested
//   RefUrgent : scheduler -> controller, refresh must preempt idle/non-RAM cycles
//   InitDone  : power-up refresh burst complete, DRAM usable
//   Overflow  : sticky, a tick arrived with debt already saturated
//   Debt      : current refresh debt
// master = scheduler side, slave = RAM controller side.
interface refresh_scheduler_if;
  logic       RefAck;
  logic       RefReq;
  logic       RefUrgent;
  logic       InitDone;
  logic       Overflow;
  logic [3:0] Debt;

  modport master (input RefAck, output RefReq, RefUrgent, InitDone, Overflow, Debt);
  modport slave  (output RefAck, input RefReq, RefUrgent, InitDone, Overflow, Debt);
endinterface

// File: rtl/refresh_scheduler.sv
// refresh_scheduler: DRAM refresh request generator.
// Counts refresh intervals, keeps a saturating refresh debt, raises urgency
// as debt grows and runs a mandatory power-up refresh burst.
//   CLK  : system clock
//   nRES : asynchronous active-low reset
//   bus  : refresh_scheduler_if.master (RefAck in; RefReq, RefUrgent,
//          InitDone, Overflow, Debt out; all outputs registered)
module refresh_scheduler #(
  parameter int PERIOD    = 384,
  parameter int MAXDEBT   = 8,
  parameter int URGENT_AT = 3,
  parameter int INIT_REFS = 8,
  parameter int GAP       = 2
) (
  input  logic                 CLK,
  input  logic                 nRES,
  refresh_scheduler_if.master  bus
);

  localparam int TW = $clog2(PERIOD);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {M_LOAD, M_INIT, M_RUN} mode_t;
  typedef enum logic [1:0] {R_IDLE, R_ASSERT, R_GAP} req_t;

  mode_t         mode, modeNext;
  req_t          reqSt, reqNext;
  logic [TW-1:0] timer, timerNext;
  logic [GW-1:0] gapCnt, gapNext;
  logic [3:0]    debt, debtNext;
  logic          overflow, ovfNext;
  logic          initDone, initNext;
  logic          refReq, refUrgent, urgNext;
  logic          tick, ackEff;

  // Acks only count while a request is actually outstanding.
  assign tick   = (mode == M_RUN) && (timer == TW'(PERIOD - 1));
  assign ackEff = bus.RefAck && (reqSt == R_ASSERT);

  always_comb begin
    debtNext  = debt;
    ovfNext   = overflow;
    modeNext  = mode;
    initNext  = initDone;
    timerNext = timer;
    reqNext   = reqSt;
    gapNext   = gapCnt;

    // Debt: tick and ack on the same cycle cancel (no overflow either).
    if (tick && !ackEff) begin
      if (debt == 4'(MAXDEBT)) ovfNext = 1'b1;
      else                     debtNext = debt + 4'd1;
    end else if (ackEff && !tick && debt != 4'd0) begin
      debtNext = debt - 4'd1;
    end

    case (mode)
      M_LOAD: begin
        debtNext = 4'(INIT_REFS);
        modeNext = M_INIT;
      end
      M_INIT: begin
        // Timer stays at 0, so the first tick lands PERIOD cycles after InitDone.
        if (debtNext == 4'd0) begin
          initNext = 1'b1;
          modeNext = M_RUN;
        end
      end
      default: timerNext = tick ? '0 : timer + 1'b1;
    endcase

    // Request FSM looks at the registered debt: debt visible in cycle N
    // gives RefReq in N+1.
    case (reqSt)
      R_IDLE:   if (debt != 4'd0) reqNext = R_ASSERT;
      R_ASSERT: if (ackEff) begin
        reqNext = R_GAP;
        gapNext = GW'(GAP);
      end
      R_GAP: begin
        // The last gap cycle performs the idle check directly, so RefReq is
        // low for exactly GAP cycles before a back-to-back re-assert.
        gapNext = gapCnt - 1'b1;
        if (gapCnt == GW'(1)) reqNext = (debt != 4'd0) ? R_ASSERT : R_IDLE;
      end
      default: reqNext = R_IDLE;
    endcase

    urgNext = (reqNext == R_ASSERT) &&
              ((mode == M_INIT) || (debtNext >= 4'(URGENT_AT)));
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      mode      <= M_LOAD;
      reqSt     <= R_IDLE;
      timer     <= '0;
      gapCnt    <= '0;
      debt      <= 4'd0;
      overflow  <= 1'b0;
      initDone  <= 1'b0;
      refReq    <= 1'b0;
      refUrgent <= 1'b0;
    end else begin
      mode      <= modeNext;
      reqSt     <= reqNext;
      timer     <= timerNext;
      gapCnt    <= gapNext;
      debt      <= debtNext;
      overflow  <= ovfNext;
      initDone  <= initNext;
      refReq    <= (reqNext == R_ASSERT);
      refUrgent <= urgNext;
    end
  end

  assign bus.RefReq    = refReq;
  assign bus.RefUrgent = refUrgent;
  assign bus.InitDone  = initDone;
  assign bus.Overflow  = overflow;
  assign bus.Debt      = debt;

endmodule

// File: tb/tb_refresh_scheduler.sv
// tb_refresh_scheduler: table-driven power-up vectors, directed corner-case
// sequences and randomized acks, all compared every cycle against a
// behavioural model of the refresh rules.
module tb_refresh_scheduler;
  localparam int PERIOD = 384, MAXDEBT = 8, URGENT_AT = 3, INIT_REFS = 8, GAP = 2;

  logic CLK = 1'b0;
  logic nRES;
  refresh_scheduler_if bus();

  refresh_scheduler #(.PERIOD(PERIOD), .MAXDEBT(MAXDEBT), .URGENT_AT(URGENT_AT),
                      .INIT_REFS(INIT_REFS), .GAP(GAP))
    dut (.CLK(CLK), .nRES(nRES), .bus(bus));

  always #5 CLK = ~CLK;

  int nChecks = 0, nErrors = 0;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owed refreshes, outstanding request, forced-low cycles.
  bit mLoad, mDone, mReq, mUrg, mOvf;
  int mDebt, mBlk, mPh;

  function automatic void modelReset();
    mLoad = 1; mDone = 0; mReq = 0; mUrg = 0; mOvf = 0;
    mDebt = 0; mBlk = 0; mPh = 0;
  endfunction

  function automatic void modelEdge(bit a);
    bit eff, tick, nreq;
    int d;
    eff  = a && mReq;
    tick = mDone && (mPh == PERIOD - 1);
    if (mReq)          nreq = !eff;
    else if (mBlk > 0) nreq = 0;
    else               nreq = (mDebt > 0);
    if (eff) mBlk = GAP - 1;
    else if (!mReq && mBlk > 0) mBlk--;
    d = mDebt;
    if (tick && !eff) begin
      if (d == MAXDEBT) mOvf = 1; else d++;
    end else if (eff && !tick && d > 0) d--;
    if (mLoad) d = INIT_REFS;
    mUrg = nreq && ((!mLoad && !mDone) || d >= URGENT_AT);
    if (mLoad) mLoad = 0;
    else if (!mDone) begin
      if (d == 0) begin mDone = 1; mPh = 0; end
    end else mPh = (mPh + 1) % PERIOD;
    mReq = nreq;
    mDebt = d;
  endfunction

  // Observation bookkeeping over a phase.
  int rises, urgRises, urgCyc, lowRun, minLow, hiCnt;
  bit prevReq;

  function automatic void clrObs();
    rises = 0; urgRises = 0; urgCyc = 0; lowRun = 0; minLow = 1000; prevReq = 0;
  endfunction

  task automatic step(input bit a);
    bus.RefAck = a;
    @(posedge CLK);
    modelEdge(a);
    #1;
    chk("model RefReq",    int'(bus.RefReq),    int'(mReq));
    chk("model RefUrgent", int'(bus.RefUrgent), int'(mUrg));
    chk("model InitDone",  int'(bus.InitDone),  int'(mDone));
    chk("model Overflow",  int'(bus.Overflow),  int'(mOvf));
    chk("model Debt",      int'(bus.Debt),      mDebt);
    if (bus.RefUrgent) urgCyc++;
    if (bus.RefReq && !prevReq) begin
      if (rises > 0 && lowRun < minLow) minLow = lowRun;
      rises++;
      if (bus.RefUrgent) urgRises++;
    end
    if (bus.RefReq) lowRun = 0; else lowRun++;
    prevReq = bus.RefReq;
    hiCnt = bus.RefReq ? hiCnt + 1 : 0;
  endtask

  // Controller acks three cycles after each RefReq rise.
  task automatic initBurst();
    int n;
    n = 0;
    while (!bus.InitDone && n < 200) begin
      step(hiCnt == 4);
      n++;
    end
    chk("init burst finished", int'(bus.InitDone), 1);
    chk("init RefReq pulses", rises, INIT_REFS);
    chk("init urgent pulses", urgRises, INIT_REFS);
    chk("init gap >= GAP", int'(minLow >= GAP), 1);
    chk("init Debt", int'(bus.Debt), 0);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, " RefReq"},    int'(bus.RefReq), 0);
    chk({tag, " RefUrgent"}, int'(bus.RefUrgent), 0);
    chk({tag, " InitDone"},  int'(bus.InitDone), 0);
    chk({tag, " Overflow"},  int'(bus.Overflow), 0);
    chk({tag, " Debt"},      int'(bus.Debt), 0);
  endtask

  typedef struct {
    bit ack; bit req; bit urg; bit done; int debt;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n;
    tbl[0]  = '{0, 0, 0, 0, 8};
    tbl[1]  = '{0, 1, 1, 0, 8};
    tbl[2]  = '{0, 1, 1, 0, 8};
    tbl[3]  = '{0, 1, 1, 0, 8};
    tbl[4]  = '{0, 1, 1, 0, 8};
    tbl[5]  = '{1, 0, 0, 0, 7};
    tbl[6]  = '{0, 0, 0, 0, 7};
    tbl[7]  = '{0, 1, 1, 0, 7};
    tbl[8]  = '{0, 1, 1, 0, 7};
    tbl[9]  = '{0, 1, 1, 0, 7};
    tbl[10] = '{0, 1, 1, 0, 7};
    tbl[11] = '{1, 0, 0, 0, 6};

    nRES = 1'b0;
    bus.RefAck = 1'b0;
    hiCnt = 0;
    repeat (3) @(posedge CLK);
    #1;
    chkAllZero("reset");
    nRES = 1'b1;
    modelReset();
    clrObs();

    // Power-up burst: first two refreshes from the vector table.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].ack);
      chk($sformatf("vec%0d RefReq", i),    int'(bus.RefReq),    int'(tbl[i].req));
      chk($sformatf("vec%0d RefUrgent", i), int'(bus.RefUrgent), int'(tbl[i].urg));
      chk($sformatf("vec%0d InitDone", i),  int'(bus.InitDone),  int'(tbl[i].done));
      chk($sformatf("vec%0d Debt", i),      int'(bus.Debt),      tbl[i].debt);
    end
    initBurst();

    // Steady state, prompt acks: one request per interval, never urgent.
    clrObs();
    repeat (2 * PERIOD + 10) step(bus.RefReq);
    chk("steady requests", rises, 2);
    chk("steady urgent cycles", urgCyc, 0);
    chk("steady Debt", int'(bus.Debt), 0);

    // Acks withheld for three intervals.
    repeat (3 * PERIOD) step(1'b0);
    chk("withheld Debt", int'(bus.Debt), 3);
    chk("withheld RefReq", int'(bus.RefReq), 1);
    chk("withheld RefUrgent", int'(bus.RefUrgent), 1);
    step(1'b1);
    chk("ack Debt", int'(bus.Debt), 2);
    chk("ack RefReq low", int'(bus.RefReq), 0);
    chk("ack RefUrgent low", int'(bus.RefUrgent), 0);
    repeat (GAP - 1) begin
      step(1'b0);
      chk("gap RefReq low", int'(bus.RefReq), 0);
    end
    step(1'b0);
    chk("reassert RefReq", int'(bus.RefReq), 1);
    chk("reassert not urgent", int'(bus.RefUrgent), 0);

    // Saturation and sticky overflow.
    n = 0;
    while (!bus.Overflow && n < 12 * PERIOD) begin step(1'b0); n++; end
    chk("overflow seen", int'(bus.Overflow), 1);
    chk("saturated Debt", int'(bus.Debt), MAXDEBT);
    n = 0;
    while (bus.Debt != 0 && n < 500) begin step(bus.RefReq); n++; end
    chk("drained Debt", int'(bus.Debt), 0);
    chk("overflow sticky", int'(bus.Overflow), 1);
    repeat (5 * PERIOD) step(1'b0);
    chk("pre-reset Debt", int'(bus.Debt), 5);
    chk("pre-reset Overflow", int'(bus.Overflow), 1);

    // Mid-operation reset: outputs clear without a clock edge.
    #2 nRES = 1'b0;
    #1 chkAllZero("async reset");
    @(posedge CLK);
    #1;
    nRES = 1'b1;
    modelReset();
    clrObs();
    hiCnt = 0;
    initBurst();

    // Ack coincident with a tick while Debt=1, then a spurious ack in GAP.
    n = 0;
    while (!(bus.RefReq && bus.Debt == 1) && n < 2 * PERIOD + 5) begin step(1'b0); n++; end
    chk("debt1 pending", int'(bus.RefReq && bus.Debt == 1), 1);
    n = 0;
    while (mPh != PERIOD - 1 && n < PERIOD + 2) begin step(1'b0); n++; end
    step(1'b1);
    chk("tick+ack Debt", int'(bus.Debt), 1);
    chk("tick+ack RefReq", int'(bus.RefReq), 0);
    step(1'b1);
    chk("spurious gap Debt", int'(bus.Debt), 1);
    chk("spurious gap RefReq", int'(bus.RefReq), 0);
    step(1'b0);
    chk("post-gap reassert", int'(bus.RefReq), 1);
    chk("post-gap Debt", int'(bus.Debt), 1);
    step(1'b1);
    repeat (GAP + 1) step(1'b0);
    step(1'b1);
    chk("spurious idle Debt", int'(bus.Debt), 0);
    chk("spurious idle RefReq", int'(bus.RefReq), 0);

    // Randomized ack traffic against the model.
    repeat (3000) step($urandom_range(0, 3) == 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
